tt_event_sequencer: RTL
=======================

# tt_event_sequencer

Event sequencer for the time-tagging datapath. Applies per-input polarity correction to the PPS and trigger inputs, detects rising edges, and snapshots a free-running cycle counter for each edge. Arbitrates the snapshots from all sources onto one valid/ready output channel, which feeds the time-tag FIFO/AXI readout. The cycle counter restarts on every PPS.

## Interface
- CNT_W, 27: cycle-counter and timestamp width (covers 120 MHz × 1 s).
- NTRIG, 2: number of trigger inputs (1..6).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when 0, new edges are ignored; already-pending events still drain.
- pps_in  in  1  PPS input, already synchronous to clk.
- trig_in  in  NTRIG  trigger inputs, already synchronous to clk.
- pol  in  NTRIG+1  polarity: bit i inverts trig_in[i]; bit NTRIG inverts pps_in. Treat as quasi-static.
- out_valid  out  1  event word is available.
- out_ready  in  1  consumer accepts the event word.
- out_src  out  3  event source: 0 = PPS, 1+i = trig_in[i].
- out_count  out  CNT_W  captured counter value.
- lost_cnt  out  8  saturating count of dropped events.

## Operation
- **Input stage:** s = raw XOR pol, registered twice (q1, q2). Edge on a source = q1 & ~q2.
- **Cycle counter:**
  - cnt increments by 1 every clk and saturates at 2^CNT_W−1 (no wrap).
  - On a PPS edge cycle, the next cnt value is 0.
  - The counter runs regardless of enable.
- **Capture:**
  - On an edge with enable=1, the source's snap register takes the current cnt value and its pend bit is set.
  - The PPS snapshot is the pre-reset cnt value, i.e. the number of cycles in the elapsed second.
  - A trigger edge in the same cycle as a PPS edge also captures the pre-reset value.
- **Overflow:**
  - An edge on a source whose pend is still set, and is not cleared in that same cycle, is dropped; snap keeps the old value and lost_cnt increments (saturates at 255).
  - Several drops in one cycle add their count, saturating.
  - If pend is cleared in the same cycle as a new edge, the new edge is accepted.
- **Arbiter and output register (states EMPTY/FULL):**
  - Load condition: out_valid=0, or out_valid & out_ready.
  - On a load, the highest-priority pending source is moved to out_src/out_count and its pend bit is cleared.
  - Priority is fixed: PPS, then trig_in[0], trig_in[1], and so on.
  - If nothing is pending when a load occurs, out_valid goes to 0.
  - While out_valid=1 and out_ready=0, out_src and out_count are held stable.
  - Sustained throughput is 1 event per cycle.
- **enable:** Deasserting enable does not clear pend or the output register. q1/q2 keep tracking while disabled, so an edge that occurs while disabled is not captured later.
- **Reset:**
  - cnt, q1, q2, pend, snap, lost_cnt, out_valid, out_src and out_count are all 0 after the reset edge.
  - Reset mid-handshake drops the word without requiring out_ready.

## Timing
- If corrected input is first registered high at edge k (q1=1):
  - the edge is detected in cycle k→k+1;
  - snap = cnt value after edge k;
  - pend is set at edge k+1;
  - out_valid=1 after edge k+2, given an empty or accepting output.
- Latency from input sampled to out_valid is 2 cycles.
- PPS detected at edge k+1: cnt=0 after edge k+1 and 1 after edge k+2.
- Handshake transfer occurs at an edge where out_valid & out_ready.
- lost_cnt updates at the same edge as the drop.

## Test plan
- **Single trigger:** reset, pol=0, trig_in[0] high for 1 cycle, sampled at edge 10 (cnt=10 after that edge), out_ready=1 → out_valid for 1 cycle after edge 12 with out_src=1, out_count=10; lost_cnt=0.
- **PPS period:** PPS pulses every 1000 cycles, out_ready=1 → each PPS word after the first has out_count=999; cnt reads 0 on the cycle after detection.
- **Simultaneous events:** PPS and both triggers rise together, out_ready=1 → three consecutive words with out_src 0, 1, 2 and identical out_count; the next word's count is referenced to 0.
- **Backpressure/drop:** out_ready=0, three edges on trig_in[1] spaced 5 cycles apart → out_valid held with the first count; the second edge pends; the third is dropped, so lost_cnt=1. Releasing ready delivers exactly 2 words. A further 300 drops saturate lost_cnt at 255.
- **Polarity and enable:** pol[0]=1 with trig_in[0] idling high then pulsing low → the falling edge is captured. With enable=0, an edge produces no word; a word already pending still drains.
- **Reset mid-operation:** out_valid=1 with two pending and out_ready=0, assert rst for 1 cycle → all outputs 0 the next cycle and no stale words after release. Also hold with no PPS for 2^CNT_W cycles (CNT_W=8 build) → cnt saturates at 255.

Source files
------------

// File: rtl/tt_event_sequencer.sv
// Event sequencer: polarity-corrected edge detection on PPS and triggers, cycle-counter
// snapshots, and fixed-priority arbitration onto a single valid/ready output channel.
module tt_event_sequencer #(
  parameter int unsigned CNT_W = 27,
  parameter int unsigned NTRIG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pps_in,
  input  logic [NTRIG-1:0] trig_in,
  input  logic [NTRIG:0]   pol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_src,
  output logic [CNT_W-1:0] out_count,
  output logic [7:0]       lost_cnt
);

  localparam int unsigned NSRC = NTRIG + 1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state;
  logic [NSRC-1:0]  s, q1, q2, edge_det, pend, clr, cap, drop;
  logic [CNT_W-1:0] cnt, cnt_next, sel_snap;
  logic [CNT_W-1:0] snap [NSRC];
  logic             load, any_pend, found;
  logic [2:0]       sel;
  logic [3:0]       drop_num;
  logic [8:0]       lost_sum;
  logic [7:0]       lost_next;

  // Source 0 is PPS (polarity bit NTRIG); source 1+i is trig_in[i].
  always_comb begin
    s        = {trig_in ^ pol[NTRIG-1:0], pps_in ^ pol[NTRIG]};
    edge_det = q1 & ~q2;
  end

  always_comb begin
    load     = (state == StEmpty) || out_ready;
    any_pend = |pend;
    found    = 1'b0;
    sel      = '0;
    sel_snap = '0;
    clr      = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (pend[i] && !found) begin
        found    = 1'b1;
        sel      = 3'(i);
        sel_snap = snap[i];
        clr[i]   = load;
      end
    end
  end

  // A pend bit freed by the arbiter in the same cycle can accept a new edge.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      cap[i]   = edge_det[i] & enable & (~pend[i] | clr[i]);
      drop[i]  = edge_det[i] & enable & pend[i] & ~clr[i];
      drop_num = drop_num + 4'(drop[i]);
    end
    lost_sum  = {1'b0, lost_cnt} + 9'(drop_num);
    lost_next = lost_sum[8] ? 8'hff : lost_sum[7:0];
  end

  always_comb begin
    if (edge_det[0]) begin
      cnt_next = '0;
    end else if (&cnt) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1        <= '0;
      q2        <= '0;
      cnt       <= '0;
      pend      <= '0;
      lost_cnt  <= '0;
      state     <= StEmpty;
      out_src   <= '0;
      out_count <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        snap[i] <= '0;
      end
    end else begin
      q1       <= s;
      q2       <= q1;
      cnt      <= cnt_next;
      lost_cnt <= lost_next;
      for (int i = 0; i < int'(NSRC); i++) begin
        if (cap[i]) begin
          snap[i] <= cnt;
        end
        pend[i] <= cap[i] | (pend[i] & ~clr[i]);
      end
      if (load) begin
        state <= any_pend ? StFull : StEmpty;
        if (any_pend) begin
          out_src   <= sel;
          out_count <= sel_snap;
        end
      end
    end
  end

  assign out_valid = (state == StFull);

endmodule
